// File: rtl/pb_key_mailbox.sv
// -----------------------------------------------------------------------------
// pb_key_mailbox
//
// Key mailbox between two KCPSM3 cores. The key-generator core (producer)
// pushes bytes into a FIFO with OUTPUT to PUSH_PORT. The cipher core (consumer)
// pops them with INPUT from KEY_PORT. The consumer's in_port is a registered
// mux over FIFO head, status, occupancy and NUM_CH external channels. Sticky
// overflow/underflow flags are cleared by a consumer OUTPUT to STATUS_PORT.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   prod_port_id          producer port_id
//   prod_out_port         producer out_port (push data)
//   prod_write_strobe     producer write_strobe
//   prod_in_port          registered producer status {0.., overflow, full}
//   cons_port_id          consumer port_id
//   cons_out_port         consumer out_port (bit2 clears overflow, bit3 underflow)
//   cons_write_strobe     consumer write_strobe
//   cons_read_strobe      consumer read_strobe (pop on KEY_PORT)
//   cons_in_port          registered consumer in_port mux
//   ext_in                NUM_CH external channels, channel k at [k*DATA_W +: DATA_W]
//   full, empty           decoded from the occupancy count
//   overflow, underflow   sticky error flags
// -----------------------------------------------------------------------------
module pb_key_mailbox #(
  parameter int         DATA_W      = 8,
  parameter int         DEPTH       = 16,
  parameter int         NUM_CH      = 4,
  parameter logic [7:0] PUSH_PORT   = 8'h10,
  parameter logic [7:0] KEY_PORT    = 8'h80,
  parameter logic [7:0] STATUS_PORT = 8'h81,
  parameter logic [7:0] COUNT_PORT  = 8'h82
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               prod_port_id,
  input  logic [DATA_W-1:0]        prod_out_port,
  input  logic                     prod_write_strobe,
  output logic [DATA_W-1:0]        prod_in_port,
  input  logic [7:0]               cons_port_id,
  input  logic [DATA_W-1:0]        cons_out_port,
  input  logic                     cons_write_strobe,
  input  logic                     cons_read_strobe,
  output logic [DATA_W-1:0]        cons_in_port,
  input  logic [NUM_CH*DATA_W-1:0] ext_in,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Occupancy update; push acceptance is gated upstream so the count
  // can never pass DEPTH or drop below zero.
  function automatic logic [CW-1:0] count_next(input logic [CW-1:0] cur,
                                               input logic           inc,
                                               input logic           dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    case ({inc, dec})
      2'b10:   nxt = cur + CW'(1);
      2'b01:   nxt = cur - CW'(1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Sticky flag: a set in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic cur,
                                       input logic set,
                                       input logic clr);
    return set | (cur & ~clr);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [CW-1:0]     count;

  logic              push_req_p0;
  logic              pop_req_p0;
  logic              clr_req_p0;
  logic              push_ok_p0;
  logic              pop_ok_p0;
  logic              ovf_set_p0;
  logic              unf_set_p0;
  logic              ovf_clr_p0;
  logic              unf_clr_p0;
  logic [DATA_W-1:0] ext_sel_p0;
  logic [DATA_W-1:0] cons_mux_p0;
  logic              unused_cons_bits;

  // Only bits 2 and 3 of the consumer write data carry meaning.
  assign unused_cons_bits = ^cons_out_port;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // ---- stage p0: port decode and FIFO control ----
  assign push_req_p0 = prod_write_strobe & (prod_port_id == PUSH_PORT);
  assign pop_req_p0  = cons_read_strobe  & (cons_port_id == KEY_PORT);
  assign clr_req_p0  = cons_write_strobe & (cons_port_id == STATUS_PORT);

  // A pop at full frees an entry for a simultaneous push; DEPTH >= 2 means
  // full and empty are never true together.
  assign pop_ok_p0  = pop_req_p0 & ~empty;
  assign push_ok_p0 = push_req_p0 & (~full | pop_ok_p0);
  assign ovf_set_p0 = push_req_p0 & ~push_ok_p0;
  assign unf_set_p0 = pop_req_p0 & empty;
  assign ovf_clr_p0 = clr_req_p0 & cons_out_port[2];
  assign unf_clr_p0 = clr_req_p0 & cons_out_port[3];

  // External channel select; a single channel ignores the port_id bits.
  generate
    if (NUM_CH > 1) begin : g_multi_ch
      localparam int SW = $clog2(NUM_CH);
      logic [DATA_W-1:0] ext_ch [NUM_CH];
      logic [SW-1:0]     ch_sel;
      for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ext_ch[k] = ext_in[k*DATA_W +: DATA_W];
      end
      assign ch_sel     = cons_port_id[SW-1:0];
      assign ext_sel_p0 = ext_ch[ch_sel];
    end else begin : g_single_ch
      assign ext_sel_p0 = ext_in[DATA_W-1:0];
    end
  endgenerate

  always_comb begin
    cons_mux_p0 = ext_sel_p0;
    if (cons_port_id == KEY_PORT) begin
      cons_mux_p0 = empty ? '0 : mem[rptr];
    end else if (cons_port_id == STATUS_PORT) begin
      cons_mux_p0 = DATA_W'({4'b0000, underflow, overflow, full, empty});
    end else if (cons_port_id == COUNT_PORT) begin
      cons_mux_p0 = DATA_W'(count);
    end
  end

  // ---- stage p1: registered state and port outputs ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      cons_in_port <= '0;
      prod_in_port <= '0;
    end else begin
      if (push_ok_p0) wptr <= wptr + AW'(1);
      if (pop_ok_p0)  rptr <= rptr + AW'(1);
      count        <= count_next(count, push_ok_p0, pop_ok_p0);
      overflow     <= sticky_next(overflow, ovf_set_p0, ovf_clr_p0);
      underflow    <= sticky_next(underflow, unf_set_p0, unf_clr_p0);
      // Registered a cycle ahead of the KCPSM3 capture, so a KEY_PORT read
      // returns the head as it stood before the pop on the capture edge.
      cons_in_port <= cons_mux_p0;
      prod_in_port <= DATA_W'({6'b000000, overflow, full});
    end
  end

  // Storage carries data only; it is never reset.
  always_ff @(posedge clk) begin
    if (push_ok_p0) mem[wptr] <= prod_out_port;
  end

endmodule

// File: tb/tb_pb_key_mailbox.sv
module tb_pb_key_mailbox;

  localparam int         DATA_W = 8;
  localparam int         DEPTH  = 16;
  localparam int         NUM_CH = 4;
  localparam logic [7:0] PUSH   = 8'h10;
  localparam logic [7:0] KEY    = 8'h80;
  localparam logic [7:0] STAT   = 8'h81;
  localparam logic [7:0] CNT    = 8'h82;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [7:0]               prod_port_id;
  logic [DATA_W-1:0]        prod_out_port;
  logic                     prod_write_strobe;
  logic [DATA_W-1:0]        prod_in_port;
  logic [7:0]               cons_port_id;
  logic [DATA_W-1:0]        cons_out_port;
  logic                     cons_write_strobe;
  logic                     cons_read_strobe;
  logic [DATA_W-1:0]        cons_in_port;
  logic [NUM_CH*DATA_W-1:0] ext_in;
  logic                     full;
  logic                     empty;
  logic                     overflow;
  logic                     underflow;

  pb_key_mailbox #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH),
    .PUSH_PORT(PUSH), .KEY_PORT(KEY), .STATUS_PORT(STAT), .COUNT_PORT(CNT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .prod_port_id(prod_port_id), .prod_out_port(prod_out_port),
    .prod_write_strobe(prod_write_strobe), .prod_in_port(prod_in_port),
    .cons_port_id(cons_port_id), .cons_out_port(cons_out_port),
    .cons_write_strobe(cons_write_strobe), .cons_read_strobe(cons_read_strobe),
    .cons_in_port(cons_in_port), .ext_in(ext_in),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, req);
    end
  endtask

  // Monitor: the consumer captures cons_in_port during its read_strobe cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && cons_read_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: got %h, expected no read", cons_in_port);
      end else begin
        e = exp_q.pop_front();
        check(e.tag, cons_in_port, e.val);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    prod_port_id      = PUSH;
    prod_out_port     = d;
    prod_write_strobe = 1'b1;
    tick();
    prod_write_strobe = 1'b0;
    tick();
  endtask

  // KCPSM3 INPUT: port_id for two cycles, read_strobe in the second.
  task automatic cons_input(input logic [7:0] id, input logic [7:0] req, input string tag);
    exp_q.push_back('{val: req, tag: tag});
    cons_port_id     = id;
    cons_read_strobe = 1'b0;
    tick();
    cons_read_strobe = 1'b1;
    tick();
    cons_read_strobe = 1'b0;
  endtask

  task automatic cons_output(input logic [7:0] id, input logic [7:0] d);
    cons_port_id      = id;
    cons_out_port     = d;
    cons_write_strobe = 1'b1;
    tick();
    cons_write_strobe = 1'b0;
  endtask

  // Push and pop land on the same edge.
  task automatic push_pop(input logic [7:0] d, input logic [7:0] req, input string tag);
    exp_q.push_back('{val: req, tag: tag});
    cons_port_id  = KEY;
    prod_port_id  = PUSH;
    prod_out_port = d;
    tick();
    cons_read_strobe  = 1'b1;
    prod_write_strobe = 1'b1;
    tick();
    cons_read_strobe  = 1'b0;
    prod_write_strobe = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] d;
    int         waited;

    ext_in            = {8'h40, 8'h30, 8'h20, 8'h10};
    cons_out_port     = '0;
    cons_write_strobe = 1'b0;

    // Reset held during traffic
    reset_n           = 1'b0;
    prod_port_id      = PUSH;
    prod_out_port     = 8'hAB;
    prod_write_strobe = 1'b1;
    cons_port_id      = STAT;
    cons_read_strobe  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_empty", {7'b0, empty}, 8'h01);
    check("rst_full", {7'b0, full}, 8'h00);
    check("rst_overflow", {7'b0, overflow}, 8'h00);
    check("rst_underflow", {7'b0, underflow}, 8'h00);
    check("rst_cons_in_port", cons_in_port, 8'h00);
    check("rst_prod_in_port", prod_in_port, 8'h00);
    @(posedge clk);
    #1;
    prod_write_strobe = 1'b0;
    cons_read_strobe  = 1'b0;
    reset_n           = 1'b1;
    tick();

    cons_input(CNT, 8'h00, "count_after_reset");
    cons_input(KEY, 8'h00, "key_read_empty");
    cons_input(STAT, 8'h09, "status_underflow");
    cons_output(STAT, 8'h08);
    cons_input(STAT, 8'h01, "status_underflow_cleared");

    // Ordering
    push(8'hA5);
    push(8'h3C);
    push(8'hFF);
    cons_input(CNT, 8'h03, "count_three");
    cons_input(KEY, 8'hA5, "order_0");
    cons_input(KEY, 8'h3C, "order_1");
    cons_input(KEY, 8'hFF, "order_2");
    check("empty_after_order", {7'b0, empty}, 8'h01);
    cons_input(STAT, 8'h01, "status_after_order");

    // Fill and overflow
    for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i));
    check("full_flag", {7'b0, full}, 8'h01);
    check("prod_status_full", prod_in_port, 8'h01);
    push(8'h77);
    check("prod_status_overflow", prod_in_port, 8'h03);
    check("overflow_flag", {7'b0, overflow}, 8'h01);
    cons_input(CNT, 8'h10, "count_full");
    cons_input(STAT, 8'h06, "status_full_ovf");
    cons_output(STAT, 8'h04);
    cons_input(STAT, 8'h02, "status_ovf_cleared");

    // Push and pop together while full
    push_pop(8'h11, 8'h40, "simul_full_head");
    check("simul_full_no_ovf", {7'b0, overflow}, 8'h00);
    cons_input(CNT, 8'h10, "simul_full_count");
    cons_input(STAT, 8'h02, "simul_full_status");
    for (int i = 1; i < DEPTH; i++) cons_input(KEY, 8'h40 + 8'(i), "drain_full");
    cons_input(KEY, 8'h11, "simul_pushed_last");
    check("empty_after_drain", {7'b0, empty}, 8'h01);

    // Push and pop together while empty
    push_pop(8'h22, 8'h00, "simul_empty_read");
    cons_input(STAT, 8'h08, "simul_empty_status");
    cons_input(CNT, 8'h01, "simul_empty_count");

    // Sticky clear with both flags set
    for (int i = 0; i < DEPTH - 1; i++) push(8'h60 + 8'(i));
    push(8'h99);
    cons_input(KEY, 8'h22, "head_22");
    cons_input(STAT, 8'h0C, "status_both_flags");
    cons_output(STAT, 8'h04);
    cons_input(STAT, 8'h08, "clear_overflow_only");
    cons_output(STAT, 8'h08);
    cons_input(STAT, 8'h00, "clear_underflow");
    push(8'h70);
    prod_port_id      = PUSH;
    prod_out_port     = 8'hEE;
    prod_write_strobe = 1'b1;
    cons_port_id      = STAT;
    cons_out_port     = 8'h04;
    cons_write_strobe = 1'b1;
    tick();
    prod_write_strobe = 1'b0;
    cons_write_strobe = 1'b0;
    tick();
    cons_input(STAT, 8'h06, "set_beats_clear");
    for (int i = 0; i < DEPTH - 1; i++) cons_input(KEY, 8'h60 + 8'(i), "drain_sticky");
    cons_input(KEY, 8'h70, "drain_last_70");
    cons_input(STAT, 8'h05, "status_empty_ovf");
    cons_output(STAT, 8'h0C);
    cons_input(STAT, 8'h01, "status_all_clear");

    // External channel mux
    cons_input(8'h02, 8'h30, "ext_ch2");
    cons_input(8'h83, 8'h40, "ext_ch3");
    cons_input(8'h00, 8'h10, "ext_ch0");

    // Pointer wrap
    for (int i = 0; i < 40; i++) begin
      d = 8'(i * 7 + 3);
      push(d);
      cons_input(KEY, d, "wrap");
    end
    cons_input(STAT, 8'h01, "status_after_wrap");
    cons_input(CNT, 8'h00, "count_after_wrap");

    // Reset mid-transfer
    push(8'h5A);
    push(8'h5B);
    prod_port_id      = PUSH;
    prod_out_port     = 8'h5C;
    prod_write_strobe = 1'b1;
    reset_n           = 1'b0;
    #1;
    check("midrst_empty", {7'b0, empty}, 8'h01);
    check("midrst_full", {7'b0, full}, 8'h00);
    tick();
    tick();
    prod_write_strobe = 1'b0;
    reset_n           = 1'b1;
    tick();
    cons_input(CNT, 8'h00, "midrst_count");
    cons_input(KEY, 8'h00, "midrst_key_empty");

    // Let the monitor consume anything still queued
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
